drv_sar_adc_multi: RTL and testbench
====================================

# drv_sar_adc_multi

Parametrised multi-channel driver for LTC232x-family simultaneous-sampling SAR ADCs with one serial data lane per channel. It generates CNV and SCK, deserialises all lanes in parallel, and optionally averages 2^N back-to-back conversions per channel. It runs free-running or on an external trigger, and reports trigger overruns. It sits between the ADC pins and the AXI register/stream logic of the ADC IP, in place of the fixed 8-channel driver.

## Interface
- NUM_CH, 8: number of SDO lanes/channels (1..16)
- DATA_BITS, 14: result bits per channel (two's complement, MSB first on the wire)
- FRAME_BITS, 16: SCK periods per conversion frame (>= DATA_BITS, <= 31)
- CNV_CYCLES, 6: CNV high time in clk cycles (>= 1)
- ACQ_CYCLES, 90: CNV-low-to-first-SCK wait in clk cycles (>= 1)
- HANG_CYCLES, 200: dead time after each frame in clk cycles (>= 1)
- clk  in  1  system clock, 200 MHz nominal
- rst  in  1  asynchronous reset, active-high
- enable  in  1  1 = allow new batches; 0 = stop after the current batch
- trig_mode  in  1  0 = free-run, 1 = start a batch on trigger
- trigger  in  1  single-cycle start request, used only when trig_mode = 1
- clkdiv  in  2  SCK divisor: 00 = /2, 01 = /4, 10 = /8, 11 = /16
- os_log2  in  2  averaging depth: batch = 2^os_log2 conversions (1, 2, 4 or 8)
- overrun_clr  in  1  clears overrun
- CNV  out  1  ADC convert strobe
- SCK  out  1  ADC serial clock, idle low
- SDO  in  NUM_CH  serial data, lane i = channel i
- data  out  NUM_CH*DATA_BITS  averaged results; channel i at [i*DATA_BITS +: DATA_BITS]
- data_valid  out  1  one-cycle strobe when data updates
- busy  out  1  high whenever the FSM is not in IDLE
- overrun  out  1  sticky flag: a trigger arrived while busy

## Operation
- Reset values: CNV = 0, SCK = 0, data = 0, data_valid = 0, busy = 0, overrun = 0. The FSM resets to IDLE, and all counters and accumulators reset to 0.
- FSM states are IDLE, CNV, ACQ, RECV, HANG.
- IDLE:
  - Leaves to CNV when enable = 1 and either trig_mode = 0 or trigger = 1.
  - On leaving, it latches clkdiv and os_log2 (both held for the whole batch) and clears the accumulators and the conversion counter.
- CNV: CNV = 1 for exactly CNV_CYCLES cycles, then go to ACQ.
- ACQ: CNV = 0 for ACQ_CYCLES cycles, then go to RECV. Entry to RECV clears the SCK divider and the bit counter.
- SCK generation:
  - A 4-bit phase accumulator adds 8, 4, 2 or 1 per clk for clkdiv 00, 01, 10, 11 respectively.
  - SCK = accumulator[3] in RECV; SCK = 0 in all other states.
- Bit capture:
  - The shift strobe fires on the clk cycle where the accumulator equals 1000, 1100, 1110 or 1111 (per clkdiv), i.e. just before the SCK falling edge.
  - Each strobe shifts SDO[i] into the LSB of per-channel shift register i and increments the bit counter.
  - After FRAME_BITS strobes, RECV ends.
  - The result is the first DATA_BITS bits received; the trailing FRAME_BITS-DATA_BITS bits are discarded.
- Accumulation:
  - At the end of RECV, each result is sign-extended to DATA_BITS+3 bits and added to its channel accumulator.
  - If fewer than 2^os_log2 conversions are done, go to HANG and then CNV (enable is not rechecked mid-batch).
  - Otherwise, data[i] = accumulator[i] arithmetically shifted right by os_log2, truncated to DATA_BITS. No rounding; the result floors toward negative infinity. data_valid pulses and the FSM goes to HANG.
- HANG: wait HANG_CYCLES cycles. Then go to CNV if the batch is unfinished, otherwise to IDLE (the IDLE rules decide the restart).
- Overrun:
  - trigger = 1 with trig_mode = 1 while busy = 1 sets overrun; that trigger is dropped (no queueing).
  - overrun_clr clears overrun. When set and clear coincide, set wins.
- enable falling mid-batch: the batch completes and data_valid is issued, then the FSM stays in IDLE.
- rst mid-operation: all outputs go immediately (asynchronously) to their reset values. The partial batch is discarded.

## Timing
- clkdiv /D gives an SCK period of D clk cycles; the frame lasts FRAME_BITS*D cycles.
- With trigger high in IDLE at edge k, CNV rises at edge k+1 and falls at edge k+1+CNV_CYCLES.
- The first SCK rising edge occurs at edge k+1+CNV_CYCLES+ACQ_CYCLES+D/2.
- For os_log2 = 0, data_valid is high for the single cycle after edge k+1+CNV_CYCLES+ACQ_CYCLES+FRAME_BITS*D+1. With defaults and /2 this is k+130.
- data and data_valid update on the same edge. data holds until the next data_valid.
- busy rises on the edge that leaves IDLE and falls on the edge that enters IDLE.
- Free-run with enable held high: the next CNV rises HANG_CYCLES+1 cycles after data_valid.
- Conversion period = CNV_CYCLES+ACQ_CYCLES+FRAME_BITS*D+HANG_CYCLES+2 cycles.

## Test plan
- Defaults, trig_mode = 1, one trigger, ADC model drives lane i = 0x1000+i, clkdiv = 00:
  - data_valid at trigger+130 cycles; data[i] = 0x1000+i.
  - CNV high for 6 cycles; exactly 16 SCK pulses.
- clkdiv sweep 00..11 on the same stimulus: SCK period is 2/4/8/16 cycles, 16 pulses each, identical data.
- os_log2 = 2, lane 0 returns 100, 101, 102, 104 (decimal), lane 1 returns -1, -2, -1, -2:
  - One data_valid per batch; data[0] = 101, data[1] = -2.
- A trigger while busy sets overrun; the dropped trigger starts no conversion. overrun_clr asserted in the same cycle as a new overrun trigger leaves overrun = 1.
- Free-run, enable dropped during conversion 2 of a 4-deep batch: the batch completes, one data_valid, then IDLE with busy = 0 and CNV = 0.
- rst asserted mid-RECV: CNV, SCK, busy and data_valid are 0 immediately, data = 0. After release with enable = 1 and trig_mode = 0, the first CNV rises 1 cycle later.

Source files
------------

// File: rtl/drv_sar_adc_multi_if.sv
// drv_sar_adc_multi_if: ADC pin bundle (CNV/SCK/SDO) plus the averaged-result bus.
interface drv_sar_adc_multi_if #(
    parameter int NUM_CH    = 8,
    parameter int DATA_BITS = 14
) ();
    logic                        CNV;
    logic                        SCK;
    logic [NUM_CH-1:0]           SDO;
    logic [NUM_CH*DATA_BITS-1:0] data;
    logic                        data_valid;
    modport master (output CNV, SCK, data, data_valid, input SDO);
    modport slave (input CNV, SCK, data, data_valid, output SDO);
endinterface

// File: rtl/drv_sar_adc_multi.sv
// drv_sar_adc_multi: multi-lane LTC232x SAR ADC driver with CNV/SCK generation,
// parallel lane capture and optional 2^N conversion averaging.
module drv_sar_adc_multi #(
    parameter int NUM_CH      = 8,
    parameter int DATA_BITS   = 14,
    parameter int FRAME_BITS  = 16,
    parameter int CNV_CYCLES  = 6,
    parameter int ACQ_CYCLES  = 90,
    parameter int HANG_CYCLES = 200
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                trig_mode,
    input  logic                trigger,
    input  logic [1:0]          clkdiv,
    input  logic [1:0]          os_log2,
    input  logic                overrun_clr,
    output logic                busy,
    output logic                overrun,
    drv_sar_adc_multi_if.master adc
);
    localparam int ACC_W = DATA_BITS + 3;
    localparam int MAXC  = CNV_CYCLES > ACQ_CYCLES ?
                           (CNV_CYCLES > HANG_CYCLES ? CNV_CYCLES : HANG_CYCLES) :
                           (ACQ_CYCLES > HANG_CYCLES ? ACQ_CYCLES : HANG_CYCLES);
    localparam int CW    = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, CNV, ACQ, RECV, HANG} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [3:0]              phase, inc, nxt_phase;
    logic [4:0]              bits;
    logic [2:0]              conv;
    logic [1:0]              dv, os;
    logic                    fin, start, strobe, done;
    logic [DATA_BITS-1:0]    sr [NUM_CH];
    logic signed [ACC_W-1:0] acc [NUM_CH];
    logic signed [ACC_W-1:0] sum [NUM_CH];

    always_comb begin
        inc       = 4'd8 >> dv;
        nxt_phase = phase + inc;
        strobe    = nxt_phase == 4'd0;
        done      = conv == (3'd1 << os) - 3'd1;
        start     = enable && (!trig_mode || trigger);
        for (int i = 0; i < NUM_CH; i++)
            sum[i] = acc[i] + {{3{sr[i][DATA_BITS-1]}}, sr[i]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            phase          <= '0;
            bits           <= '0;
            conv           <= '0;
            dv             <= '0;
            os             <= '0;
            fin            <= 1'b0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
            adc.CNV        <= 1'b0;
            adc.SCK        <= 1'b0;
            adc.data       <= '0;
            adc.data_valid <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                sr[i]  <= '0;
                acc[i] <= '0;
            end
        end else begin
            adc.data_valid <= 1'b0;
            overrun        <= (trig_mode && trigger && busy) || (overrun && !overrun_clr);
            case (state)
                IDLE: if (start) begin
                    state   <= CNV;
                    adc.CNV <= 1'b1;
                    busy    <= 1'b1;
                    cnt     <= '0;
                    dv      <= clkdiv;
                    os      <= os_log2;
                    conv    <= '0;
                    for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
                end
                CNV: if (cnt == CW'(CNV_CYCLES - 1)) begin
                    state   <= ACQ;
                    adc.CNV <= 1'b0;
                    cnt     <= '0;
                end else cnt <= cnt + CW'(1);
                ACQ: if (cnt == CW'(ACQ_CYCLES - 1)) begin
                    state <= RECV;
                    cnt   <= '0;
                    phase <= '0;
                    bits  <= '0;
                end else cnt <= cnt + CW'(1);
                RECV: if (bits == 5'(FRAME_BITS)) begin
                    state <= HANG;
                    fin   <= done;
                    conv  <= conv + 3'd1;
                    for (int i = 0; i < NUM_CH; i++) begin
                        acc[i] <= sum[i];
                        if (done) adc.data[i*DATA_BITS +: DATA_BITS] <= DATA_BITS'(sum[i] >>> os);
                    end
                    adc.data_valid <= done;
                end else begin
                    phase   <= nxt_phase;
                    adc.SCK <= nxt_phase[3];
                    // only the leading DATA_BITS bits are kept; trailing frame bits are clocked out but ignored
                    if (strobe) begin
                        bits <= bits + 5'd1;
                        if (bits < 5'(DATA_BITS))
                            for (int i = 0; i < NUM_CH; i++) sr[i] <= {sr[i][DATA_BITS-2:0], adc.SDO[i]};
                    end
                end
                HANG: if (cnt == CW'(HANG_CYCLES - 1)) begin
                    cnt     <= '0;
                    state   <= fin ? IDLE : CNV;
                    adc.CNV <= !fin;
                    busy    <= !fin;
                end else cnt <= cnt + CW'(1);
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_drv_sar_adc_multi.sv
// tb_drv_sar_adc_multi: directed bench for drv_sar_adc_multi with a behavioural
// 8-lane ADC model that shifts a 16-bit frame (14 data bits + trailing 2'b10) MSB first.
module tb_drv_sar_adc_multi;
    logic       clk = 1'b0, rst = 1'b1, enable = 1'b0, trig_mode = 1'b1, trigger = 1'b0, overrun_clr = 1'b0;
    logic [1:0] clkdiv = 2'd0, os_log2 = 2'd0;
    logic       busy, overrun;
    int         n_cmp = 0, n_bad = 0;
    logic [13:0] vals [8][8];
    int         cc = 0, conv_base = 0, cnv_hi = 0, sck_rises = 0, dv_cnt = 0;
    longint     last_rise = 0, sck_per = 0;
    logic [2:0] cur = 3'd0;
    logic [4:0] idx = 5'd0;

    drv_sar_adc_multi_if #(.NUM_CH(8), .DATA_BITS(14)) adc ();
    drv_sar_adc_multi #(.NUM_CH(8), .DATA_BITS(14)) dut (
        .clk(clk), .rst(rst), .enable(enable), .trig_mode(trig_mode), .trigger(trigger),
        .clkdiv(clkdiv), .os_log2(os_log2), .overrun_clr(overrun_clr),
        .busy(busy), .overrun(overrun), .adc(adc));

    always #5 clk = ~clk;

    // ADC model: new frame on CNV rise, next bit after each SCK fall
    always @(posedge adc.CNV or negedge adc.SCK)
        if (adc.CNV) begin
            cur = 3'(cc - conv_base);
            cc++;
            idx = 5'd0;
        end else if (!idx[4]) idx = idx + 5'd1;

    always_comb
        for (int i = 0; i < 8; i++)
            adc.SDO[i] = idx < 5'd14 ? vals[cur][i][4'd13 - idx[3:0]] : idx == 5'd14;

    always @(negedge clk) begin
        if (adc.CNV) cnv_hi++;
        if (adc.data_valid) dv_cnt++;
    end

    always @(posedge adc.SCK) begin
        sck_rises++;
        sck_per   = ($time - last_rise) / 10;
        last_rise = $time;
    end

    task automatic set_ramp();
        for (int c = 0; c < 8; c++)
            for (int i = 0; i < 8; i++) vals[c][i] = 14'h1000 + 14'(i);
    endtask

    task automatic set_os();
        for (int c = 0; c < 8; c++)
            for (int i = 0; i < 8; i++) vals[c][i] = 14'd0;
        vals[0][0] = 14'd100; vals[1][0] = 14'd101; vals[2][0] = 14'd102; vals[3][0] = 14'd104;
        vals[0][1] = 14'h3FFF; vals[1][1] = 14'h3FFE; vals[2][1] = 14'h3FFF; vals[3][1] = 14'h3FFE;
    endtask

    task automatic pulse_trigger();
        @(negedge clk) trigger = 1'b1;
        @(negedge clk) trigger = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_timeout: busy=%b after %0d cycles, expected 0", busy, n); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (adc.CNV !== 1'b0) begin n_bad++; $display("FAIL reset_cnv: got %b, expected 0", adc.CNV); end
        n_cmp++; if (adc.SCK !== 1'b0) begin n_bad++; $display("FAIL reset_sck: got %b, expected 0", adc.SCK); end
        n_cmp++; if (adc.data !== '0) begin n_bad++; $display("FAIL reset_data: got %h, expected 0", adc.data); end
        n_cmp++; if (adc.data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dv: got %b, expected 0", adc.data_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b, expected 0", overrun); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_no_enable: busy=%b, expected 0", busy); end
    endtask

    task automatic test_single(input logic [1:0] div);
        int d = 2 << div;
        int n = 0;
        int c0, s0, h0, v0;
        logic [111:0] want;
        for (int i = 0; i < 8; i++) want[i*14 +: 14] = 14'h1000 + 14'(i);
        set_ramp();
        clkdiv = div; os_log2 = 2'd0; trig_mode = 1'b1; enable = 1'b1; conv_base = cc;
        c0 = cc; s0 = sck_rises; h0 = cnv_hi; v0 = dv_cnt;
        @(negedge clk) trigger = 1'b1;
        do begin @(negedge clk); trigger = 1'b0; n++; end while (adc.data_valid !== 1'b1 && n < 1000);
        n_cmp++; if (n != 98 + 16 * d) begin n_bad++; $display("FAIL latency_d%0d: got %0d, expected %0d", d, n, 98 + 16 * d); end
        n_cmp++; if (cnv_hi - h0 != 6) begin n_bad++; $display("FAIL cnv_width_d%0d: got %0d, expected 6", d, cnv_hi - h0); end
        n_cmp++; if (sck_rises - s0 != 16) begin n_bad++; $display("FAIL sck_pulses_d%0d: got %0d, expected 16", d, sck_rises - s0); end
        n_cmp++; if (sck_per != longint'(d)) begin n_bad++; $display("FAIL sck_period_d%0d: got %0d, expected %0d", d, sck_per, d); end
        n_cmp++; if (adc.data !== want) begin n_bad++; $display("FAIL data_d%0d: got %h, expected %h", d, adc.data, want); end
        wait_idle(400);
        n_cmp++; if (dv_cnt - v0 != 1 || cc - c0 != 1) begin n_bad++; $display("FAIL single_counts_d%0d: dv=%0d cnv=%0d, expected 1 1", d, dv_cnt - v0, cc - c0); end
    endtask

    task automatic test_oversample();
        int c0, v0;
        set_os();
        clkdiv = 2'd0; os_log2 = 2'd2; trig_mode = 1'b1; enable = 1'b1; conv_base = cc;
        c0 = cc; v0 = dv_cnt;
        pulse_trigger();
        wait_idle(2000);
        n_cmp++; if (dv_cnt - v0 != 1) begin n_bad++; $display("FAIL os_dv_count: got %0d, expected 1", dv_cnt - v0); end
        n_cmp++; if (cc - c0 != 4) begin n_bad++; $display("FAIL os_conversions: got %0d, expected 4", cc - c0); end
        n_cmp++; if (adc.data[13:0] !== 14'd101) begin n_bad++; $display("FAIL os_lane0: got %0d, expected 101", adc.data[13:0]); end
        n_cmp++; if (adc.data[27:14] !== 14'h3FFE) begin n_bad++; $display("FAIL os_lane1: got %h, expected 3ffe", adc.data[27:14]); end
        n_cmp++; if (adc.data[111:28] !== '0) begin n_bad++; $display("FAIL os_lanes_rest: got %h, expected 0", adc.data[111:28]); end
    endtask

    task automatic test_overrun();
        int c0, v0;
        set_ramp();
        clkdiv = 2'd0; os_log2 = 2'd0; trig_mode = 1'b1; enable = 1'b1; conv_base = cc;
        c0 = cc; v0 = dv_cnt;
        pulse_trigger();
        n_cmp++; if (overrun !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL ovr_idle_trig: overrun=%b busy=%b, expected 0 1", overrun, busy); end
        repeat (10) @(negedge clk);
        pulse_trigger();
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b, expected 1", overrun); end
        wait_idle(600);
        repeat (20) @(negedge clk);
        n_cmp++; if (cc - c0 != 1 || dv_cnt - v0 != 1) begin n_bad++; $display("FAIL ovr_dropped: cnv=%0d dv=%0d, expected 1 1", cc - c0, dv_cnt - v0); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b, expected 1", overrun); end
        @(negedge clk) overrun_clr = 1'b1;
        @(negedge clk) overrun_clr = 1'b0;
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear: got %b, expected 0", overrun); end
        pulse_trigger();
        repeat (5) @(negedge clk);
        @(negedge clk) begin trigger = 1'b1; overrun_clr = 1'b1; end
        @(negedge clk) begin trigger = 1'b0; overrun_clr = 1'b0; end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set_wins: got %b, expected 1", overrun); end
        @(negedge clk) overrun_clr = 1'b1;
        @(negedge clk) overrun_clr = 1'b0;
        wait_idle(600);
    endtask

    task automatic test_enable_drop();
        int c0, v0;
        int n = 0;
        set_os();
        clkdiv = 2'd0; os_log2 = 2'd2; trig_mode = 1'b0; conv_base = cc;
        c0 = cc; v0 = dv_cnt;
        @(negedge clk) enable = 1'b1;
        while (cc - c0 < 2 && n < 1000) begin @(negedge clk); n++; end
        n_cmp++; if (cc - c0 != 2) begin n_bad++; $display("FAIL en_reach_conv2: got %0d, expected 2", cc - c0); end
        enable = 1'b0;
        wait_idle(2000);
        n_cmp++; if (dv_cnt - v0 != 1) begin n_bad++; $display("FAIL en_dv_count: got %0d, expected 1", dv_cnt - v0); end
        n_cmp++; if (cc - c0 != 4) begin n_bad++; $display("FAIL en_conversions: got %0d, expected 4", cc - c0); end
        n_cmp++; if (adc.CNV !== 1'b0) begin n_bad++; $display("FAIL en_cnv_low: got %b, expected 0", adc.CNV); end
        n_cmp++; if (adc.data[13:0] !== 14'd101) begin n_bad++; $display("FAIL en_lane0: got %0d, expected 101", adc.data[13:0]); end
        repeat (400) @(negedge clk);
        n_cmp++; if (cc - c0 != 4 || busy !== 1'b0) begin n_bad++; $display("FAIL en_stays_idle: cnv=%0d busy=%b, expected 4 0", cc - c0, busy); end
    endtask

    task automatic test_reset_mid();
        int s0;
        int n = 0;
        set_ramp();
        clkdiv = 2'd0; os_log2 = 2'd0; trig_mode = 1'b0; conv_base = cc;
        s0 = sck_rises;
        @(negedge clk) enable = 1'b1;
        while (sck_rises - s0 < 4 && n < 300) begin @(negedge clk); n++; end
        n_cmp++; if (sck_rises - s0 < 4) begin n_bad++; $display("FAIL rst_reach_recv: sck=%0d, expected 4", sck_rises - s0); end
        rst = 1'b1;
        #1;
        n_cmp++; if (adc.CNV !== 1'b0 || adc.SCK !== 1'b0) begin n_bad++; $display("FAIL rst_async_pins: cnv=%b sck=%b, expected 0 0", adc.CNV, adc.SCK); end
        n_cmp++; if (busy !== 1'b0 || adc.data_valid !== 1'b0) begin n_bad++; $display("FAIL rst_async_busy_dv: busy=%b dv=%b, expected 0 0", busy, adc.data_valid); end
        n_cmp++; if (adc.data !== '0) begin n_bad++; $display("FAIL rst_async_data: got %h, expected 0", adc.data); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (adc.CNV !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL rst_restart: cnv=%b busy=%b, expected 1 1", adc.CNV, busy); end
        enable = 1'b0;
        wait_idle(500);
    endtask

    initial begin
        test_reset();
        for (int d = 0; d < 4; d++) test_single(2'(d));
        test_oversample();
        test_overrun();
        test_enable_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
